// File: rtl/vram_pkg.sv
// Shared constants and encodings for the video-RAM arbiter.
// Frame-buffer geometry, memory widths, clear-FSM states and slot-owner codes.
package vram_pkg;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int FB_SIZE     = FB_W * FB_H;
    localparam int SCALE_SHIFT = 2;
    localparam int AW          = 15;
    localparam int DW          = 8;

    // Last cell address; the clear engine stops after writing it.
    localparam logic [AW-1:0] FB_LAST = AW'(FB_SIZE - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    typedef enum logic [1:0] {
        SLOT_NONE = 2'd0,
        SLOT_DISP = 2'd1,
        SLOT_CLR  = 2'd2,
        SLOT_HOST = 2'd3
    } slot_e;

    // True when a cell address lies inside the frame buffer.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return addr < AW'(FB_SIZE);
    endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Scan position to frame-buffer cell address.
// Purely combinational: each coordinate is shifted down to cell units, the row
// is multiplied by the frame-buffer width at full width, then truncated to AW.
module vram_addr_gen
    import vram_pkg::*;
(
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    output logic [AW-1:0] cell_addr
);

    logic [9:0]  cell_x;
    logic [9:0]  cell_y;
    logic [31:0] full_addr;

    // Row-major cell address at full precision, then truncated.
    always_comb begin
        cell_x    = pixel_x >> SCALE_SHIFT;
        cell_y    = pixel_y >> SCALE_SHIFT;
        full_addr = 32'(cell_y) * 32'(FB_W) + 32'(cell_x);
        cell_addr = full_addr[AW-1:0];
    end

    // High product bits are dropped by design.
    logic unused_hi;
    assign unused_hi = ^full_addr[31:AW];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter and sequencer.
// Each clk one owner drives the RAM: display read, clear write, host access or
// idle, in that priority. Display data returns on pix_data two clk after the
// address; host reads return one clk after the ack.
// Optional clear engine: define VRAM_ARB_CLEAR_EN to build it; without it the
// clear ports are kept, busy/clear_done stay low and the host owns every
// non-display slot.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          video_on,
    input  logic          p_tick,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          clear_start,
    output logic          busy,
    output logic          clear_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_data
);

    logic [AW-1:0] disp_addr;
    slot_e         slot;
    logic          clr_busy;
    logic          clr_start_acc;
    logic [AW-1:0] clr_addr;
    logic          host_in_range;

    vram_addr_gen u_addr_gen (
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .cell_addr (disp_addr)
    );

`ifdef VRAM_ARB_CLEAR_EN
    clr_state_e    state_q,   state_d;
    logic [AW-1:0] cnt_q,     cnt_d;
    logic          done_q,    done_d;

    // Clear FSM next state: walk the counter over every cell on clear slots.
    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (slot == SLOT_CLR) begin
                    if (cnt_q == FB_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear FSM state, counter and done pulse; reset abandons a clear in flight.
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy      = (state_q == ST_CLEAR);
    assign clr_start_acc = (state_q == ST_IDLE) && clear_start;
    assign clr_addr      = cnt_q;
    assign clear_done    = done_q;
`else
    assign clr_busy      = 1'b0;
    assign clr_start_acc = 1'b0;
    assign clr_addr      = '0;
    assign clear_done    = 1'b0;

    logic unused_clear;
    assign unused_clear = clear_start;
`endif

    assign busy          = clr_busy;
    assign host_in_range = addr_in_range(host_addr);

    // Slot owner: display, then clear, then host; a host request loses to a
    // clear being accepted in the same cycle.
    always_comb begin
        slot = SLOT_NONE;
        if (!reset) begin
            if (p_tick && video_on)
                slot = SLOT_DISP;
            else if (clr_busy)
                slot = SLOT_CLR;
            else if (host_req && !clr_start_acc)
                slot = SLOT_HOST;
        end
    end

    // RAM command for the current owner; out-of-range host writes are dropped.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (slot)
            SLOT_DISP: mem_addr = disp_addr;
            SLOT_CLR: begin
                mem_addr = clr_addr;
                mem_we   = 1'b1;
            end
            SLOT_HOST: begin
                mem_addr  = host_addr;
                mem_we    = host_we && host_in_range;
                mem_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    assign host_ack = (slot == SLOT_HOST);

    logic          host_rvalid_q, host_rvalid_d;
    logic          rd_oob_q,      rd_oob_d;
    logic          disp_q,        disp_d;
    logic          blank_q,       blank_d;
    logic [DW-1:0] pix_data_q,    pix_data_d;

    // Next values for read qualifiers and the pixel register.
    always_comb begin
        host_rvalid_d = host_ack && !host_we;
        rd_oob_d      = host_ack && !host_we && !host_in_range;
        disp_d        = (slot == SLOT_DISP);
        blank_d       = p_tick && !video_on;
        pix_data_d    = pix_data_q;
        if (disp_q)
            pix_data_d = mem_rdata;
        else if (blank_q)
            pix_data_d = '0;
    end

    // Output and qualifier registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rvalid_q <= 1'b0;
            rd_oob_q      <= 1'b0;
            disp_q        <= 1'b0;
            blank_q       <= 1'b0;
            pix_data_q    <= '0;
        end else begin
            host_rvalid_q <= host_rvalid_d;
            rd_oob_q      <= rd_oob_d;
            disp_q        <= disp_d;
            blank_q       <= blank_d;
            pix_data_q    <= pix_data_d;
        end
    end

    // The RAM's own output register supplies the read data; it is gated by
    // registered qualifiers so host_rdata is zero outside rvalid and for
    // out-of-range reads.
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = (host_rvalid_q && !rd_oob_q) ? mem_rdata : '0;
    assign pix_data    = pix_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural synchronous RAM.
// Host read results are predicted from a shadow memory and queued at issue,
// then popped when host_rvalid appears. Clear-engine scenarios follow
// VRAM_ARB_CLEAR_EN.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    pixel_x, pixel_y;
    logic          video_on, p_tick;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          clear_start, busy, clear_done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] pix_data;

    vram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .p_tick      (p_tick),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM.
    logic [7:0] ram     [0:32767];
    logic [7:0] exp_mem [0:32767];
    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [7:0] rd_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Read scoreboard: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (host_rvalid === 1'b1) begin
            if (rd_q.size() == 0) check("rvalid_unexpected", host_rvalid, 0);
            else                  check("host_rdata", host_rdata, rd_q.pop_front());
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        p_tick = ~p_tick;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd,
                           input int max_wait, output int waited, output logic tick_at_ack);
        logic acked;
        logic in_rng;
        acked       = 1'b0;
        waited      = 0;
        tick_at_ack = 1'b0;
        in_rng      = (int'(addr) < FB_SIZE);
        step();
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        if (!we) rd_q.push_back(in_rng ? exp_mem[addr] : 8'h00);
        while (!acked && waited < max_wait) begin
            sample();
            waited++;
            if (host_ack === 1'b1) begin
                acked       = 1'b1;
                tick_at_ack = p_tick;
                check("host_mem_we", mem_we, we && in_rng);
                if (in_rng) check("host_mem_addr", mem_addr, addr);
                if (we && in_rng) check("host_mem_wdata", mem_wdata, wd);
            end else begin
                step();
            end
        end
        if (!acked) begin
            check("host_ack_timeout", host_ack, 1);
            if (!we) void'(rd_q.pop_back());
        end
        step();
        host_req = 1'b0;
        if (acked && we && in_rng) exp_mem[addr] = wd;
        sample();
        check("host_rvalid", host_rvalid, acked && !we);
        check("host_ack_pulse", host_ack, 0);
    endtask

    int          px [4] = '{4, 639, 13, 3};
    int          py [4] = '{4, 479, 9, 3};
    int          ea [4] = '{161, 19199, 323, 0};
    logic [7:0]  dv [4] = '{8'h5A, 8'h77, 8'hA5, 8'h0F};

    int   w;
    logic t;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            exp_mem[i] = ram[i];
        end
        for (int i = 0; i < 4; i++) begin
            ram[ea[i]]     = dv[i];
            exp_mem[ea[i]] = dv[i];
        end
        ram[19200] = 8'hEE;

        reset       = 1'b1;
        pixel_x     = '0;
        pixel_y     = '0;
        video_on    = 1'b0;
        p_tick      = 1'b0;
        host_req    = 1'b0;
        host_we     = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        clear_start = 1'b0;

        // Reset state.
        repeat (3) step();
        sample();
        check("rst_host_ack",    host_ack, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_host_rdata",  host_rdata, 0);
        check("rst_busy",        busy, 0);
        check("rst_clear_done",  clear_done, 0);
        check("rst_pix_data",    pix_data, 0);
        check("rst_mem_we",      mem_we, 0);
        step();
        reset = 1'b0;

        // Display reads: address on a p_tick cycle, pix_data two clk later.
        for (int i = 0; i < 4; i++) begin
            do step(); while (p_tick !== 1'b1);
            pixel_x  = 10'(px[i]);
            pixel_y  = 10'(py[i]);
            video_on = 1'b1;
            sample();
            check("disp_addr", mem_addr, ea[i]);
            check("disp_we", mem_we, 0);
            step();
            sample();
            step();
            sample();
            check("pix_data", pix_data, dv[i]);
        end

        // Blanking p_tick clears pix_data two clk later.
        do step(); while (p_tick !== 1'b1);
        video_on = 1'b0;
        step();
        sample();
        check("pix_hold", pix_data, dv[3]);
        step();
        sample();
        check("pix_blank_zero", pix_data, 0);

        // Host accesses during active video: served on a p_tick=0 slot.
        video_on = 1'b1;
        pixel_x  = '0;
        pixel_y  = '0;
        host_op(1'b1, 15'h0100, 8'hC3, 4, w, t);
        check("wr_video_wait_le2", w <= 2, 1);
        check("wr_video_ack_tick", t, 0);
        host_op(1'b0, 15'h0100, 8'h00, 4, w, t);
        check("rd_video_wait_le2", w <= 2, 1);
        check("rd_video_ack_tick", t, 0);
        host_op(1'b0, 15'd161, 8'h00, 4, w, t);

        // Host accesses during blanking: served in the request cycle.
        video_on = 1'b0;
        host_op(1'b1, 15'h2000, 8'h96, 4, w, t);
        check("wr_blank_wait", w, 1);
        host_op(1'b0, 15'h2000, 8'h00, 4, w, t);
        check("rd_blank_wait", w, 1);

        // Out-of-range host accesses: acked, write suppressed, read returns 0.
        host_op(1'b1, 15'd19200, 8'h55, 4, w, t);
        check("oob_wr_wait", w, 1);
        host_op(1'b0, 15'd19200, 8'h00, 4, w, t);
        check("oob_rd_wait", w, 1);

`ifdef VRAM_ARB_CLEAR_EN
        begin
            int   wr_cnt, addr_err, ack_busy, done_cnt, last_wr_cyc, done_cyc, exp_a, n;
            logic done_busy, got_ack;
            wr_cnt = 0; addr_err = 0; ack_busy = 0; done_cnt = 0;
            last_wr_cyc = -10; done_cyc = -1; exp_a = 0; done_busy = 1'b1; got_ack = 1'b0;

            // Clear during active video with a host write requested in the
            // same cycle the clear is accepted.
            video_on = 1'b1;
            do step(); while (p_tick !== 1'b0);
            clear_start = 1'b1;
            host_req    = 1'b1;
            host_we     = 1'b1;
            host_addr   = 15'h0100;
            host_wdata  = 8'h3E;
            sample();
            check("host_loses_to_clear", host_ack, 0);
            step();
            clear_start = 1'b0;
            n = 0;
            while (!got_ack && n < 45000) begin
                sample();
                if (busy === 1'b1) begin
                    if (mem_we === 1'b1) begin
                        wr_cnt++;
                        if (int'(mem_addr) != exp_a || mem_wdata !== 8'h00) addr_err++;
                        exp_a++;
                        last_wr_cyc = cyc;
                    end
                    if (host_ack === 1'b1) ack_busy++;
                end
                if (clear_done === 1'b1) begin
                    done_cnt++;
                    done_cyc  = cyc;
                    done_busy = busy;
                end
                if (host_ack === 1'b1 && busy === 1'b0) begin
                    got_ack = 1'b1;
                    check("post_clear_host_we",   mem_we, 1);
                    check("post_clear_host_addr", mem_addr, 15'h0100);
                end else begin
                    step();
                    // A second start part-way through must be ignored.
                    clear_start = (wr_cnt == 100);
                    n++;
                end
            end
            step();
            host_req    = 1'b0;
            clear_start = 1'b0;
            repeat (5) begin
                sample();
                if (clear_done === 1'b1) done_cnt++;
                step();
            end
            for (int i = 0; i < FB_SIZE; i++) exp_mem[i] = 8'h00;
            if (got_ack) exp_mem[16'h0100] = 8'h3E;
            check("clear_write_count",  wr_cnt, FB_SIZE);
            check("clear_addr_errors",  addr_err, 0);
            check("host_ack_while_busy", ack_busy, 0);
            check("host_ack_after_clear", got_ack, 1);
            check("clear_done_count",   done_cnt, 1);
            check("clear_done_timing",  done_cyc, last_wr_cyc + 1);
            check("busy_at_clear_done", done_busy, 0);

            host_op(1'b0, 15'h0100, 8'h00, 4, w, t);
            host_op(1'b0, 15'd161, 8'h00, 4, w, t);
            host_op(1'b0, 15'h2000, 8'h00, 4, w, t);

            // Reset part-way through a clear.
            video_on = 1'b0;
            step();
            clear_start = 1'b1;
            step();
            clear_start = 1'b0;
            repeat (100) step();
            sample();
            check("busy_before_reset", busy, 1);
            step();
            reset = 1'b1;
            sample();
            check("rst_mid_busy",        busy, 0);
            check("rst_mid_clear_done",  clear_done, 0);
            check("rst_mid_host_ack",    host_ack, 0);
            check("rst_mid_host_rvalid", host_rvalid, 0);
            check("rst_mid_pix_data",    pix_data, 0);
            check("rst_mid_mem_we",      mem_we, 0);
            step();
            reset = 1'b0;
            done_cnt = 0;
            n = 0;
            repeat (50) begin
                sample();
                if (clear_done === 1'b1) done_cnt++;
                if (busy === 1'b1) n++;
                step();
            end
            check("no_done_after_reset", done_cnt, 0);
            check("idle_after_reset",    n, 0);
        end
`else
        begin
            int flags;
            // clear_start is ignored; host takes the very next free slot.
            video_on = 1'b0;
            step();
            clear_start = 1'b1;
            host_req    = 1'b1;
            host_we     = 1'b0;
            host_addr   = 15'h2000;
            rd_q.push_back(exp_mem[16'h2000]);
            sample();
            check("noclr_busy",      busy, 0);
            check("noclr_host_ack",  host_ack, 1);
            step();
            clear_start = 1'b0;
            host_req    = 1'b0;
            sample();
            check("noclr_rvalid", host_rvalid, 1);
            flags = 0;
            repeat (20) begin
                step();
                sample();
                if (busy !== 1'b0 || clear_done !== 1'b0) flags++;
            end
            check("noclr_busy_done_low", flags, 0);

            // Reset with display activity in progress.
            video_on = 1'b1;
            step();
            reset = 1'b1;
            sample();
            check("rst_mid_mem_we",   mem_we, 0);
            check("rst_mid_pix_data", pix_data, 0);
            check("rst_mid_host_ack", host_ack, 0);
            step();
            reset = 1'b0;
        end
`endif

        repeat (3) step();
        sample();
        check("scoreboard_empty", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-RAM arbiter and sequencer sitting between the 640x480 VGA sync generator and the frame-buffer RAM. It converts the sync generator's scan position into frame-buffer read addresses on every pixel tick and shares the remaining memory cycles with a host read/write port. An optional clear engine fills the frame buffer with zeros. The block returns pixel data on a fixed latency so the pixel-generation circuit can align it with the registered hsync/vsync.

## Interface
- FB_W, 160, frame-buffer width in cells
- FB_H, 120, frame-buffer height in cells
- SCALE_SHIFT, 2, screen pixels per cell edge = 2^SCALE_SHIFT (640>>2 = 160)
- AW, 15, memory address width
- DW, 8, memory data width
- clk  in  1  system clock (50 MHz); single clock domain
- reset  in  1  asynchronous, active-high reset
- pixel_x, pixel_y  in  10 each  scan position from the sync generator
- video_on  in  1  scan position is inside the 640x480 display area
- p_tick  in  1  25 MHz pixel enable, high every other clk
- host_req  in  1  host access request; held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req is high
- host_addr  in  AW  host cell address; stable while host_req is high
- host_wdata  in  DW  host write data; stable while host_req is high
- host_ack  out  1  one-cycle pulse in the cycle the host access is performed
- host_rvalid  out  1  one-cycle pulse one clk after a read ack
- host_rdata  out  DW  read data, valid while host_rvalid is high
- clear_start  in  1  pulse that starts a frame-buffer clear
- busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- mem_addr  out  AW, mem_we  out  1, mem_wdata  out  DW  RAM command, combinational from the grant
- mem_rdata  in  DW  synchronous RAM read data; valid one clk after the address
- pix_data  out  DW  registered cell data for the pixel generator

## Operation
- Slot owner each clk, in priority order:
  - display, if p_tick & video_on;
  - clear engine, if busy;
  - host, if host_req;
  - otherwise idle (mem_we=0).
- Display read address = (pixel_y>>SCALE_SHIFT)*FB_W + (pixel_x>>SCALE_SHIFT). The product is computed at full width and truncated to AW.
- Because p_tick alternates, a non-clear host request is served within 2 clk during video and in 1 clk during blanking.
- Host grant drives mem_addr=host_addr, mem_we=host_we, mem_wdata=host_wdata, and host_ack=1 in the same cycle.
- Host address out of range (host_addr >= FB_W*FB_H):
  - ack is still given;
  - a write is suppressed (mem_we=0);
  - a read returns host_rdata=0 with the normal rvalid.
- Clear FSM states are IDLE and CLEAR.
  - IDLE to CLEAR on clear_start: counter=0, busy=1.
  - In CLEAR, each non-display slot writes 0 to the counter address, then the counter increments.
  - After writing address FB_W*FB_H-1: go to IDLE, busy=0, clear_done pulses in the following cycle.
  - clear_start while busy is ignored.
  - Host is stalled (no ack) while busy.
- pix_data register:
  - loads mem_rdata in the cycle after a display slot;
  - loads 0 in the cycle after a p_tick with video_on=0;
  - otherwise holds.

## Timing
- Reset values: host_ack=0, host_rvalid=0, host_rdata=0, busy=0, clear_done=0, pix_data=0, FSM=IDLE, clear counter=0, mem_we=0.
- Display latency: address issued in cycle N (p_tick=1), mem_rdata in N+1, pix_data valid from N+2 until the next load. This is 1 clk behind the registered hsync/vsync; the pixel generator delays sync by 1 further clk.
- Host read: ack in N, host_rvalid and host_rdata in N+1; host_rdata is registered.
- A host_req asserted in the cycle clear_start is accepted loses to the clear.
- Reset mid-clear: FSM goes to IDLE immediately; memory is left partially cleared; no clear_done.
- A full clear takes FB_W*FB_H non-display slots: 19200 at the defaults; at most 38400 clk during active video.

## Configuration
- VRAM_ARB_CLEAR_EN defined: clear engine and FSM are present as described.
- VRAM_ARB_CLEAR_EN undefined:
  - ports are kept; clear_start is ignored;
  - busy=0 and clear_done=0 constantly;
  - the host owns every non-display slot.

## Structure
- Package vram_pkg holds:
  - FB_W, FB_H, and FB_SIZE=FB_W*FB_H;
  - FSM state encodings (IDLE=0, CLEAR=1);
  - slot-owner encoding (NONE, DISP, CLR, HOST).
- One sub-module, vram_addr_gen, is purely combinational: scan position to cell address, including shift, multiply and truncation.
- Arbiter, FSM and output registers stay in vram_arbiter.

## Test plan
- Reset while busy with clear_start pulsed -> all outputs 0, FSM IDLE; clear_done never pulses.
- pixel_x=4, pixel_y=4, video_on=1, p_tick=1 -> mem_addr=161; mem_rdata=0x5A in N+1 -> pix_data=0x5A in N+2.
- Host write to 0x0100 with data 0xC3 during active video -> host_ack within 2 clk, on a p_tick=0 cycle; read of 0x0100 -> host_rvalid with 0xC3 one clk after ack.
- Host write to address 19200 -> ack given, mem_we stays 0; host read of 19200 -> host_rdata=0.
- clear_start during blanking -> busy=1; 19200 writes of 0 to addresses 0..19199; clear_done pulses once; busy=0. A host_req held during the clear gets its ack only after busy falls.
- Without VRAM_ARB_CLEAR_EN: clear_start pulsed -> busy and clear_done stay 0; the host is served on the next free slot.
